// File: rtl/pipe_skid_reg_pkg.sv
// Shared types and default payload constants for the skid-buffered pipeline register.
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } skid_state_e;

  localparam logic [31:0] RESET_VALUE_32 = 32'h1000_0000;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0033;

endpackage

// File: rtl/flopenrclr.sv
// Flop with synchronous reset, synchronous clear and load enable (reset > clear > enable).
module flopenrclr #(
  parameter int              WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] CLR_VALUE   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Register update: reset value, then clear value, then load of d.
  always_ff @(posedge clk) begin
    if (rst)      q <= RESET_VALUE;
    else if (clr) q <= CLR_VALUE;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready pipeline register: a head (main) register plus one skid
// register, so in_ready can be registered and never depends on out_ready.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_EMPTY | nothing held; out_data shows reset or bubble payload
//   ST_FULL  | one entry in main, skid unused
//   ST_SKID  | two entries: main is head, skid is next; in_ready low
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE  = WIDTH'(RESET_VALUE_32),
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = WIDTH'(NOP_INSTR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  skid_state_e      state, state_next;
  logic             in_ready_q;
  logic             in_xfer, out_xfer;
  logic             main_en, main_clr, skid_en, skid_clr;
  logic [WIDTH-1:0] main_d, main_q, skid_q;

  // in_ready comes from a flop; rst only masks it so nothing is accepted during reset.
  assign in_ready  = in_ready_q & ~rst;
  assign out_valid = (state == ST_FULL) || (state == ST_SKID);
  assign out_data  = main_q;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // State register and registered in_ready (low only when the next state is SKID).
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next != ST_SKID);
    end
  end

  // Next-state and register load controls; flush overrides every transfer.
  always_comb begin
    state_next = state;
    main_en    = 1'b0;
    main_clr   = 1'b0;
    main_d     = in_data;
    skid_en    = 1'b0;
    skid_clr   = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_xfer) begin
          main_en    = 1'b1;
          state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        if (in_xfer && out_xfer) begin
          main_en = 1'b1;
        end else if (in_xfer) begin
          skid_en    = 1'b1;
          state_next = ST_SKID;
        end else if (out_xfer) begin
          main_clr   = 1'b1;
          state_next = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (out_xfer) begin
          main_en    = 1'b1;
          main_d     = skid_q;
          skid_clr   = 1'b1;
          state_next = ST_FULL;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
    if (flush) begin
      state_next = ST_EMPTY;
      main_clr   = 1'b1;
      skid_clr   = 1'b1;
    end
  end

  // Occupancy decoded directly from state.
  always_comb begin
    occupancy = 2'd0;
    case (state)
      ST_FULL:  occupancy = 2'd1;
      ST_SKID:  occupancy = 2'd2;
      default:  occupancy = 2'd0;
    endcase
  end

  flopenrclr #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE),
    .CLR_VALUE   (BUBBLE_VALUE)
  ) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .clr (main_clr),
    .d   (main_d),
    .q   (main_q)
  );

  flopenrclr #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (BUBBLE_VALUE),
    .CLR_VALUE   (BUBBLE_VALUE)
  ) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .clr (skid_clr),
    .d   (in_data),
    .q   (skid_q)
  );

endmodule
